rv32v_memory_arbitor: RTL and testbench

RV32V_MEMORY_ARBITOR -- requirements
Module: rv32v_memory_arbitor

---
 rtl/rv32v_memory_arbitor.sv | 151 +++++++++++++++
 tb/tb_rv32v_memory_arbitor.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32v_memory_arbitor.sv
// rv32v_memory_arbitor: shares one memory port between the scalar and vector cores, oldest CB entry first.
// Latency: grant taken on the edge after a request is seen in IDLE; each transaction occupies >= 2 cycles.
// Backpressure: m_busy holds the locked grant; requesters see *_busy until their completion cycle. Optional perf counters under RV32V_ARB_PERF_EN.
module rv32v_memory_arbitor #(
    parameter int NUM_CB_ENTRY = 16,
    localparam int CBW = $clog2(NUM_CB_ENTRY)
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [CBW-1:0]  cb_tail_index,
    input  logic [CBW-1:0]  scalar_cb_index,
    input  logic [CBW-1:0]  vector_cb_index,
    input  logic            s_ena,
    input  logic            s_ren,
    input  logic            s_wen,
    input  logic [31:0]     s_addr,
    input  logic [31:0]     s_wdata,
    input  logic [3:0]      s_byte_en,
    output logic            s_busy,
    output logic [31:0]     s_rdata,
    input  logic            v_ena,
    input  logic            v_ren,
    input  logic            v_wen,
    input  logic [31:0]     v_addr,
    input  logic [31:0]     v_wdata,
    input  logic [3:0]      v_byte_en,
    output logic            v_busy,
    output logic [31:0]     v_rdata,
`ifdef RV32V_ARB_PERF_EN
    output logic [31:0]     s_grant_cnt,
    output logic [31:0]     v_grant_cnt,
    output logic [31:0]     conflict_cnt,
`endif
    output logic            m_ren,
    output logic            m_wen,
    output logic [31:0]     m_addr,
    output logic [31:0]     m_wdata,
    output logic [3:0]      m_byte_en,
    input  logic            m_busy,
    input  logic [31:0]     m_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        S_GNT = 2'd1,
        V_GNT = 2'd2
    } state_t;

    typedef struct packed {
        logic        ren;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  byte_en;
    } mem_req_t;

    state_t   state;
    state_t   next_state;
    mem_req_t hold;
    mem_req_t s_pkt;
    mem_req_t v_pkt;
    mem_req_t win_pkt;

    logic           s_req;
    logic           v_req;
    logic [CBW-1:0] s_age;
    logic [CBW-1:0] v_age;
    logic           grant_take;

    assign s_req = s_ena & (s_ren | s_wen);
    assign v_req = v_ena & (v_ren | v_wen);

    // Distance from the commit tail; modular subtraction handles CB wrap-around.
    assign s_age = scalar_cb_index - cb_tail_index;
    assign v_age = vector_cb_index - cb_tail_index;

    assign s_pkt = '{ren: s_ren, wen: s_wen, addr: s_addr, wdata: s_wdata, byte_en: s_byte_en};
    assign v_pkt = '{ren: v_ren, wen: v_wen, addr: v_addr, wdata: v_wdata, byte_en: v_byte_en};

    // Next-state: arbitrate only from IDLE (ties go to scalar); a grant ends on the first non-busy cycle.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (s_req && v_req) begin
                    next_state = (s_age <= v_age) ? S_GNT : V_GNT;
                end else if (s_req) begin
                    next_state = S_GNT;
                end else if (v_req) begin
                    next_state = V_GNT;
                end
            end
            S_GNT, V_GNT: begin
                if (!m_busy) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign grant_take = (state == IDLE) && (next_state != IDLE);
    assign win_pkt    = (next_state == V_GNT) ? v_pkt : s_pkt;

    // State register plus the holding copy of the winner's request, captured once so the grant is locked.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            hold  <= '0;
        end else begin
            state <= next_state;
            if (grant_take) begin
                hold <= win_pkt;
            end
        end
    end

    // Memory port strobes only while granted; address/data/byte-enables keep their last value in IDLE.
    assign m_ren     = (state != IDLE) & hold.ren;
    assign m_wen     = (state != IDLE) & hold.wen;
    assign m_addr    = hold.addr;
    assign m_wdata   = hold.wdata;
    assign m_byte_en = hold.byte_en;

    assign s_busy  = s_req & ~((state == S_GNT) & ~m_busy);
    assign v_busy  = v_req & ~((state == V_GNT) & ~m_busy);
    assign s_rdata = m_rdata;
    assign v_rdata = m_rdata;

`ifdef RV32V_ARB_PERF_EN
    // Grant and contention counters; free-running, wrap naturally at 2^32.
    always_ff @(posedge CLK) begin
        if (RST) begin
            s_grant_cnt  <= '0;
            v_grant_cnt  <= '0;
            conflict_cnt <= '0;
        end else begin
            if (grant_take && (next_state == S_GNT)) begin
                s_grant_cnt <= s_grant_cnt + 32'd1;
            end
            if (grant_take && (next_state == V_GNT)) begin
                v_grant_cnt <= v_grant_cnt + 32'd1;
            end
            if ((state == IDLE) && s_req && v_req) begin
                conflict_cnt <= conflict_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rv32v_memory_arbitor.sv
// tb_rv32v_memory_arbitor: directed scenarios plus randomized traffic against a transaction-level model.
// Latency: model advances one transaction decision per clock edge.
// Backpressure: m_busy randomized to stretch grants.
module tb_rv32v_memory_arbitor;

    localparam int NUM = 16;

    logic        CLK = 1'b0;
    logic        RST;
    logic [3:0]  cb_tail_index, scalar_cb_index, vector_cb_index;
    logic        s_ena, s_ren, s_wen, v_ena, v_ren, v_wen;
    logic [31:0] s_addr, s_wdata, v_addr, v_wdata;
    logic [3:0]  s_byte_en, v_byte_en;
    logic        s_busy, v_busy;
    logic [31:0] s_rdata, v_rdata;
    logic        m_ren, m_wen, m_busy;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_byte_en;
`ifdef RV32V_ARB_PERF_EN
    logic [31:0] s_grant_cnt, v_grant_cnt, conflict_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Model: who owns the memory port (0 none, 1 scalar, 2 vector) and the captured request.
    int          mo_owner;
    logic        mo_ren, mo_wen;
    logic [31:0] mo_addr, mo_wdata;
    logic [3:0]  mo_be;
    logic [31:0] mo_sg, mo_vg, mo_cf;

    always #5 CLK = ~CLK;

    rv32v_memory_arbitor #(.NUM_CB_ENTRY(NUM)) dut (
        .CLK(CLK), .RST(RST),
        .cb_tail_index(cb_tail_index), .scalar_cb_index(scalar_cb_index), .vector_cb_index(vector_cb_index),
        .s_ena(s_ena), .s_ren(s_ren), .s_wen(s_wen), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_byte_en(s_byte_en), .s_busy(s_busy), .s_rdata(s_rdata),
        .v_ena(v_ena), .v_ren(v_ren), .v_wen(v_wen), .v_addr(v_addr), .v_wdata(v_wdata),
        .v_byte_en(v_byte_en), .v_busy(v_busy), .v_rdata(v_rdata),
`ifdef RV32V_ARB_PERF_EN
        .s_grant_cnt(s_grant_cnt), .v_grant_cnt(v_grant_cnt), .conflict_cnt(conflict_cnt),
`endif
        .m_ren(m_ren), .m_wen(m_wen), .m_addr(m_addr), .m_wdata(m_wdata), .m_byte_en(m_byte_en),
        .m_busy(m_busy), .m_rdata(m_rdata)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int age(input logic [3:0] idx);
        return (int'(idx) - int'(cb_tail_index) + NUM) % NUM;
    endfunction

    // Model update at a clock edge, from the inputs presented during the cycle.
    task automatic model_step();
        logic sreq, vreq;
        int   win;
        sreq = s_ena & (s_ren | s_wen);
        vreq = v_ena & (v_ren | v_wen);
        if (RST) begin
            mo_owner = 0;
            {mo_ren, mo_wen, mo_addr, mo_wdata, mo_be} = '0;
            mo_sg = 0; mo_vg = 0; mo_cf = 0;
        end else if (mo_owner == 0) begin
            win = 0;
            if (sreq && vreq) begin
                mo_cf = mo_cf + 1;
                win = (age(scalar_cb_index) <= age(vector_cb_index)) ? 1 : 2;
            end else if (sreq) win = 1;
            else if (vreq) win = 2;
            if (win == 1) begin
                mo_sg = mo_sg + 1;
                {mo_ren, mo_wen, mo_addr, mo_wdata, mo_be} = {s_ren, s_wen, s_addr, s_wdata, s_byte_en};
            end else if (win == 2) begin
                mo_vg = mo_vg + 1;
                {mo_ren, mo_wen, mo_addr, mo_wdata, mo_be} = {v_ren, v_wen, v_addr, v_wdata, v_byte_en};
            end
            mo_owner = win;
        end else if (!m_busy) begin
            mo_owner = 0;
        end
    endtask

    // Compare every output against the model, a little after the inputs settled.
    task automatic compare_outputs();
        logic sreq, vreq;
        #1;
        sreq = s_ena & (s_ren | s_wen);
        vreq = v_ena & (v_ren | v_wen);
        check_val("m_ren", 32'(m_ren), (mo_owner != 0) ? 32'(mo_ren) : 32'd0);
        check_val("m_wen", 32'(m_wen), (mo_owner != 0) ? 32'(mo_wen) : 32'd0);
        check_val("m_addr", m_addr, mo_addr);
        check_val("m_wdata", m_wdata, mo_wdata);
        check_val("m_byte_en", 32'(m_byte_en), 32'(mo_be));
        check_val("s_busy", 32'(s_busy), 32'(sreq && !(mo_owner == 1 && !m_busy)));
        check_val("v_busy", 32'(v_busy), 32'(vreq && !(mo_owner == 2 && !m_busy)));
        check_val("s_rdata", s_rdata, m_rdata);
        check_val("v_rdata", v_rdata, m_rdata);
`ifdef RV32V_ARB_PERF_EN
        check_val("s_grant_cnt", s_grant_cnt, mo_sg);
        check_val("v_grant_cnt", v_grant_cnt, mo_vg);
        check_val("conflict_cnt", conflict_cnt, mo_cf);
`endif
    endtask

    task automatic tick();
        @(posedge CLK);
        model_step();
        @(negedge CLK);
    endtask

    initial begin
        mo_owner = 0;
        {mo_ren, mo_wen, mo_addr, mo_wdata, mo_be} = '0;
        mo_sg = 0; mo_vg = 0; mo_cf = 0;
        RST = 1'b1;
        {cb_tail_index, scalar_cb_index, vector_cb_index} = '0;
        {s_ena, s_ren, s_wen, v_ena, v_ren, v_wen} = '0;
        {s_addr, s_wdata, v_addr, v_wdata} = '0;
        s_byte_en = 4'hF; v_byte_en = 4'hF;
        m_busy = 1'b0; m_rdata = '0;
        @(negedge CLK);
        tick();
        tick();

        // Reset state
        RST = 1'b0;
        compare_outputs();
        check_val("rst_m_ren", 32'(m_ren), 32'd0);
        check_val("rst_m_addr", m_addr, 32'd0);

        // Scalar-only read, two busy cycles then completion
        s_ena = 1; s_ren = 1; s_addr = 32'h100; m_busy = 1;
        compare_outputs();
        check_val("r27_idle_sbusy", 32'(s_busy), 32'd1);
        tick();
        compare_outputs();
        check_val("r27_mren", 32'(m_ren), 32'd1);
        check_val("r27_maddr", m_addr, 32'h100);
        tick();
        compare_outputs();
        check_val("r27_still_busy", 32'(s_busy), 32'd1);
        tick();
        m_busy = 0; m_rdata = 32'hDEADBEEF;
        compare_outputs();
        check_val("r27_sbusy_done", 32'(s_busy), 32'd0);
        check_val("r27_rdata", s_rdata, 32'hDEADBEEF);
        s_ena = 0;
        tick();
        compare_outputs();
        check_val("r27_idle_after", 32'(m_ren), 32'd0);

        // Both request across the CB wrap: vector (age 1) beats scalar (age 3)
        cb_tail_index = 14; scalar_cb_index = 1; vector_cb_index = 15;
        s_ena = 1; s_ren = 1; s_addr = 32'h400;
        v_ena = 1; v_ren = 1; v_addr = 32'h200; m_busy = 1;
        compare_outputs();
        tick();
        compare_outputs();
        check_val("r28_v_first", m_addr, 32'h200);
        m_busy = 0;
        compare_outputs();
        check_val("r28_vbusy_done", 32'(v_busy), 32'd0);
        check_val("r28_s_waits", 32'(s_busy), 32'd1);
        tick();
        v_ena = 0;
        compare_outputs();
        check_val("r28_gap", 32'(m_ren), 32'd0);
        tick();
        compare_outputs();
        check_val("r28_s_second", m_addr, 32'h400);
        check_val("r28_s_mren", 32'(m_ren), 32'd1);
        s_ena = 0;
        tick();

        // Scalar older, then equal ages (scalar wins the tie)
        cb_tail_index = 2; scalar_cb_index = 2; vector_cb_index = 3;
        s_ena = 1; s_addr = 32'h500; v_ena = 1; v_addr = 32'h600;
        compare_outputs();
        tick();
        compare_outputs();
        check_val("r29_s_older", m_addr, 32'h500);
        s_ena = 0; v_ena = 0;
        tick();
        scalar_cb_index = 5; vector_cb_index = 5; s_ena = 1; v_ena = 1;
        compare_outputs();
        tick();
        compare_outputs();
        check_val("r29_tie", m_addr, 32'h500);
        s_ena = 0; v_ena = 0;
        tick();

        // Locked grant: vector write while its payload and the tail move
        v_ena = 1; v_ren = 0; v_wen = 1; v_addr = 32'h200; v_wdata = 32'h1234_5678; m_busy = 1;
        compare_outputs();
        tick();
        v_addr = 32'h300; cb_tail_index = 9; v_wdata = 32'hFFFF_0000;
        compare_outputs();
        check_val("r30_lock0", m_addr, 32'h200);
        tick();
        compare_outputs();
        check_val("r30_lock1", m_addr, 32'h200);
        check_val("r30_wdata", m_wdata, 32'h1234_5678);
        m_busy = 0;
        compare_outputs();
        check_val("r30_lock2", m_addr, 32'h200);
        v_ena = 0;
        tick();

        // Reset in the middle of a scalar grant
        s_ena = 1; s_ren = 1; s_addr = 32'h700; m_busy = 1;
        compare_outputs();
        tick();
        compare_outputs();
        check_val("r31_granted", 32'(m_ren), 32'd1);
        RST = 1;
        tick();
        RST = 0; s_ena = 0;
        compare_outputs();
        check_val("r31_mren", 32'(m_ren), 32'd0);
        check_val("r31_maddr", m_addr, 32'd0);
`ifdef RV32V_ARB_PERF_EN
        check_val("r31_cnt", s_grant_cnt | v_grant_cnt | conflict_cnt, 32'd0);
`endif

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            RST             = ($urandom_range(0, 63) == 0);
            cb_tail_index   = 4'($urandom_range(0, 15));
            scalar_cb_index = 4'($urandom_range(0, 15));
            vector_cb_index = 4'($urandom_range(0, 15));
            s_ena = ($urandom_range(0, 3) != 0);
            v_ena = ($urandom_range(0, 3) != 0);
            s_ren = 1'($urandom_range(0, 1)); s_wen = 1'($urandom_range(0, 1));
            v_ren = 1'($urandom_range(0, 1)); v_wen = 1'($urandom_range(0, 1));
            s_addr = $urandom(); s_wdata = $urandom(); s_byte_en = 4'($urandom_range(0, 15));
            v_addr = $urandom(); v_wdata = $urandom(); v_byte_en = 4'($urandom_range(0, 15));
            m_busy  = ($urandom_range(0, 2) != 0);
            m_rdata = $urandom();
            compare_outputs();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
